// File: rtl/pc_pkg.sv
// Shared types for the program counter: address width, address type and the
// per-cycle operation chosen by the priority decode.
package pc_pkg;

  localparam int PC_W = 23;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [2:0] {
    HOLD,
    INC,
    JMP,
    CALL,
    RET
  } pc_op_e;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the sequencer/jump unit and pc_unit.
// master drives the requests and observes pc and stack status; slave is pc_unit.
interface pc_unit_if #(
  parameter int PC_W  = 23,
  parameter int DEPTH = 8
);

  logic                       inc;
  logic                       jmp_load;
  logic [PC_W-1:0]            jmp_addr;
  logic                       call;
  logic                       ret;
  logic [PC_W-1:0]            pc;
  logic                       stack_empty;
  logic                       stack_full;
  logic [$clog2(DEPTH):0]     depth;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output inc, jmp_load, jmp_addr, call, ret,
    input  pc, stack_empty, stack_full, depth, overflow, underflow
  );

  modport slave (
    input  inc, jmp_load, jmp_addr, call, ret,
    output pc, stack_empty, stack_full, depth, overflow, underflow
  );

endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO; push/pop take effect on the next edge, top is read combinationally.
// A push while full or a pop while empty is silently ignored; push wins if both are asserted.
module ret_stack #(
  parameter int W     = 23,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           push_data,
  output logic [W-1:0]           top,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [DW-1:0] cnt;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == DW'(DEPTH));
  assign empty   = (cnt == '0);
  assign depth   = cnt;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty & ~push;

  // With DEPTH a power of two, the low bits of cnt are the next free slot
  // and cnt-1 (mod DEPTH) is the top entry, including when full.
  assign wr_idx  = cnt[AW-1:0];
  assign top_idx = cnt[AW-1:0] - AW'(1);
  assign top     = mem[top_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (do_push) begin
      cnt <= cnt + DW'(1);
    end else if (do_pop) begin
      cnt <= cnt - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with call/return stack; all updates one cycle after the inputs are sampled.
// No backpressure: every request is accepted, with stack misuse recorded in sticky flags.
module pc_unit
  import pc_pkg::*;
#(
  parameter int PC_W  = pc_pkg::PC_W,
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  pc_unit_if.slave   bus
);

  logic [PC_W-1:0]        pc_q;
  logic [PC_W-1:0]        pc_plus1;
  logic [PC_W-1:0]        stk_top;
  logic [$clog2(DEPTH):0] stk_depth;
  logic                   stk_full;
  logic                   stk_empty;
  logic                   overflow_q;
  logic                   underflow_q;
  pc_op_e                 op;

  assign pc_plus1 = pc_q + PC_W'(1);

  // A taken call outranks ret, so call+ret pushes and never pops.
  always_comb begin
    op = HOLD;
    if (bus.jmp_load) begin
      op = bus.call ? CALL : JMP;
    end else if (bus.ret) begin
      op = RET;
    end else if (bus.inc) begin
      op = INC;
    end
  end

  ret_stack #(
    .W     (PC_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (op == CALL),
    .pop       (op == RET),
    .push_data (pc_plus1),
    .top       (stk_top),
    .depth     (stk_depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      case (op)
        JMP: pc_q <= bus.jmp_addr;
        CALL: begin
          pc_q <= bus.jmp_addr;
          if (stk_full) overflow_q <= 1'b1;
        end
        RET: begin
          if (stk_empty) underflow_q <= 1'b1;
          else           pc_q        <= stk_top;
        end
        INC:     pc_q <= pc_plus1;
        default: pc_q <= pc_q;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.depth       = stk_depth;
  assign bus.stack_full  = stk_full;
  assign bus.stack_empty = stk_empty;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: doc/pc_unit.md
# pc_unit

Program counter and return-address stack for the CPU core. Directly downstream of the jump unit: it consumes the jump unit's `pcoe`/`pcout` pair, and its current `pc` feeds back as the jump unit's `pcin` for relative branches. It also sequences plain instruction advance and subroutine call/return through a small hardware LIFO. All state is registered; every update takes effect on the next rising edge.

## Interface
- `PC_W`, 23: program counter width; must match the jump unit's address width.
- `DEPTH`, 8: return-stack entries; power of two, at least 2.

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `inc` in 1: advance the PC by one this cycle, issued by the control sequencer at end of instruction.
- `jmp_load` in 1: jump taken; connects to the jump unit's `pcoe`.
- `jmp_addr` in PC_W: jump target; connects to the jump unit's `pcout`.
- `call` in 1: current jump is a subroutine call; meaningful only with `jmp_load`.
- `ret` in 1: return from subroutine; pop the stack into the PC.
- `pc` out PC_W: current program counter; also drives the jump unit's `pcin`.
- `stack_empty` out 1: stack depth is 0.
- `stack_full` out 1: stack depth equals DEPTH.
- `depth` out $clog2(DEPTH)+1: current number of entries.
- `overflow` out 1: sticky. Set when a push is attempted while full.
- `underflow` out 1: sticky. Set when a pop is attempted while empty.

## Operation
- **Reset:** `pc`=0, `depth`=0, `stack_empty`=1, `stack_full`=0, `overflow`=0, `underflow`=0. Stack array contents are don't-care.
- **Priority each cycle:** `rst`, then `jmp_load`, then `ret`, then `inc`, then hold.
- **`jmp_load`=1, `call`=0:** `pc` ← `jmp_addr`. `ret` and `inc` are ignored.
- **`jmp_load`=1, `call`=1:** push (`pc`+1) mod 2^PC_W, then `pc` ← `jmp_addr`.
  - If the stack is full, the push is dropped, existing entries are untouched, and `overflow` is set. The jump still occurs.
- **`call`=1 with `jmp_load`=0 (call not taken):** no push. Fall through to the `ret`/`inc` rules.
- **`ret`=1, no jump:** `pc` ← top entry, `depth` decrements.
  - If the stack is empty, `pc` holds, `depth` stays 0, and `underflow` is set.
- **`ret`=1 together with a taken call:** the call wins, `ret` is ignored, and no flag is set.
- **`inc`=1 only:** `pc` ← (`pc`+1) mod 2^PC_W. 0x7FFFFF wraps to 0x000000.
- **Sticky flags:** `overflow` and `underflow` clear only on `rst`.
- **Flag derivation:** `stack_empty` and `stack_full` are derived from the registered `depth`.
- **LIFO ordering:** nested calls return in reverse order. After DEPTH pushes and DEPTH pops, `depth`=0.

## Timing
- **Latency:** every input sampled at edge N is visible on `pc`/`depth`/flags after edge N; one-cycle latency, no combinational input-to-output paths.
- **`pc` to jump unit:** `pc` is a plain register output, so the combinational path into the jump unit's adder starts at a flop.
- **Stack write:** the stack write (push) and the `pc` update happen on the same edge.
- **Stack read:** the top entry is read combinationally from the array at index `depth`-1 during the `ret` cycle, then registered into `pc`.
- **Back-to-back operations:** call/ret/call on consecutive cycles is legal with no bubbles.
- **Reset mid-operation:** `rst` asserted in any cycle overrides all other inputs at that edge. Stack contents are discarded logically because `depth` is forced to 0.

## Structure
- **Package `pc_pkg`:** `PC_W` default, `pc_t` typedef (logic [PC_W-1:0]), and the `pc_op_e` enum (HOLD, INC, JMP, CALL, RET) produced by the priority decode.
- **Sub-module `ret_stack`:** parameterised LIFO with `push`/`pop`/`push_data`/`top`/`depth`/`full`/`empty`. It ignores a push when full and a pop when empty; it does not set the sticky flags.
- **`pc_unit`:** holds the priority decode, the `pc` register, and the sticky flags, and instantiates `ret_stack`.

## Test plan
- **Reset and increment:** reset, then `inc` for 3 cycles → `pc` = 0, 1, 2, 3; `stack_empty`=1.
- **Wrap:** jump to 0x7FFFFF (`jmp_load`, `jmp_addr`=0x7FFFFF), then `inc` → `pc`=0x000000.
- **Nested call/return:** at `pc`=0x10, call to 0x200; at 0x200, call to 0x300; then `ret`, `ret` → `pc` goes 0x200, 0x300, 0x201, 0x11; `depth` goes 1, 2, 1, 0.
- **Overflow:** with DEPTH=8, 9 consecutive calls → `overflow`=1 after the 9th, `depth`=8, PC at the 9th target. 8 `ret`s then return the first 8 pushed addresses in LIFO order.
- **Underflow:** `ret` with an empty stack at `pc`=0x42 → `pc` stays 0x42 and `underflow`=1. A subsequent `rst` clears it.
- **Priority:** `jmp_load`+`ret`+`inc` in the same cycle → `pc`=`jmp_addr` and `depth` unchanged. Taken `call`+`ret` → push occurs. `rst` with `jmp_load` → `pc`=0.
